// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB and drives datapath enables.
// Optional performance counters are built only when MCFSM_PERF_CNT_EN is defined.
module multicycle_ctrl_fsm #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           opcode,
    input  logic                 alu_bcond,
    input  logic                 ecall_halt,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_source,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           ALUOp,
    output logic                 alu_out_write,
    output logic                 is_ecall,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] SRC_B_REG = 2'b00;
    localparam logic [1:0] SRC_B_4   = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_R      = 2'b01;
    localparam logic [1:0] ALUOP_BRANCH = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_BR   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    logic op_load;
    logic op_jump;
    logic op_known;

    assign op_load  = (opcode == OP_LOAD);
    assign op_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign op_known = (opcode == OP_R) || (opcode == OP_I) || op_load ||
                      (opcode == OP_STORE) || (opcode == OP_BRANCH) || op_jump;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls
    always_comb begin
        state_nxt     = state;
        pc_write      = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        ALUOp         = ALUOP_ADD;
        alu_out_write = 1'b0;
        is_ecall      = 1'b0;
        halted        = 1'b0;

        unique case (state)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    state_nxt = S_ID;
                end
            end
            S_ID: begin
                alu_src_b     = SRC_B_4;
                alu_out_write = 1'b1;
                if (opcode == OP_SYSTEM) begin
                    is_ecall = 1'b1;
                    if (ecall_halt) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_write  = 1'b1;
                        state_nxt = S_IF;
                    end
                end else if (!op_known) begin
                    pc_write  = 1'b1;
                    state_nxt = S_IF;
                end else begin
                    state_nxt = S_EX;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a     = 1'b1;
                        ALUOp         = ALUOP_R;
                        alu_out_write = 1'b1;
                        state_nxt     = S_WB;
                    end
                    OP_I: begin
                        alu_src_a     = 1'b1;
                        alu_src_b     = SRC_B_IMM;
                        ALUOp         = ALUOP_I;
                        alu_out_write = 1'b1;
                        state_nxt     = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a     = 1'b1;
                        alu_src_b     = SRC_B_IMM;
                        alu_out_write = 1'b1;
                        state_nxt     = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a = 1'b1;
                        ALUOp     = ALUOP_BRANCH;
                        if (alu_bcond) begin
                            state_nxt = S_BR;
                        end else begin
                            // Not taken: ALUOut still holds PC+4 from ID
                            pc_write  = 1'b1;
                            pc_source = 1'b1;
                            state_nxt = S_IF;
                        end
                    end
                    OP_JAL, OP_JALR: begin
                        alu_src_a = (opcode == OP_JALR);
                        alu_src_b = SRC_B_IMM;
                        pc_write  = 1'b1;
                        state_nxt = S_WB;
                    end
                    default: state_nxt = S_IF;
                endcase
            end
            S_BR: begin
                alu_src_b = SRC_B_IMM;
                pc_write  = 1'b1;
                state_nxt = S_IF;
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = op_load;
                mem_write = !op_load;
                if (mem_ready) begin
                    if (op_load) begin
                        state_nxt = S_WB;
                    end else begin
                        alu_src_b = SRC_B_4;
                        pc_write  = 1'b1;
                        state_nxt = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = op_load;
                if (!op_jump) begin
                    alu_src_b = SRC_B_4;
                    pc_write  = 1'b1;
                end
                state_nxt = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_IF;
        endcase

        // The state register sits in IF during reset, so the controls are forced quiet here
        if (!reset_n) begin
            pc_write      = 1'b0;
            pc_source     = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SRC_B_REG;
            ALUOp         = ALUOP_ADD;
            alu_out_write = 1'b0;
            is_ecall      = 1'b0;
            halted        = 1'b0;
        end
    end

`ifdef MCFSM_PERF_CNT_EN
    logic retire_c;

    // Last cycle of an instruction: leaving for IF from elsewhere, or the ECALL halt
    assign retire_c = ((state != S_IF) && (state_nxt == S_IF)) ||
                      ((state == S_ID) && (state_nxt == S_HALT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state != S_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            end
            if (retire_c) begin
                retire_cnt <= retire_cnt + CNT_WIDTH'(1);
            end
        end
    end
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: a driver issues random instructions and pushes per-instruction
// summaries from a reference model; a monitor collects the same summaries from the DUT and compares.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

    localparam int unsigned CNT_WIDTH = 32;
    localparam int unsigned N_RANDOM  = 160;
`ifdef MCFSM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [6:0]           opcode;
    logic                 alu_bcond;
    logic                 ecall_halt;
    logic                 mem_ready;
    logic                 pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
    logic                 mem_to_reg, reg_write, alu_src_a, alu_out_write, is_ecall, halted;
    logic [1:0]           alu_src_b, ALUOp;
    logic [CNT_WIDTH-1:0] cycle_cnt, retire_cnt;
    logic [14:0]          ctl;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_bcond(alu_bcond),
        .ecall_halt(ecall_halt), .mem_ready(mem_ready), .pc_write(pc_write),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
        .alu_out_write(alu_out_write), .is_ecall(is_ecall), .halted(halted),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    assign ctl = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, ALUOp, alu_out_write, is_ecall};

    typedef struct packed {
        logic [6:0]  op;
        logic        bcond;
        logic        ehalt;
        int unsigned if_stall;
        int unsigned mem_stall;
    } stim_t;

    // Per-instruction summary: cycle count, memory activity, PC/RF writes and the ALU modes used
    typedef struct packed {
        int cycles; int fetch_cyc; int drd; int dwr; int pcw; int pcsrc; int pwab;
        int regw; int m2r; int aow; int both; int mask; int ecall; int halts;
    } rec_t;

    rec_t            exp_q[$];
    stim_t           plan[$];
    rec_t            acc;
    bit              acc_on;
    bit              prev_stall;
    longint unsigned sum_cyc, sum_ret;
    int              total = 0;
    int              bad = 0;
    int              issued = 0;
    bit              issue_en = 1'b0;
    int              hcnt = 0;

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input longint unsigned v);
        return PERF ? 64'(v & ((64'd1 << CNT_WIDTH) - 64'd1)) : 64'd0;
    endfunction

    // Reference model: what one instruction should look like from outside, derived from its class
    function automatic rec_t model(input stim_t s);
        rec_t e;
        bit r, im, ld, st, br, jal, jalr, ec, known;
        e = '0;
        r = (s.op == OP_R); im = (s.op == OP_I); ld = (s.op == OP_LOAD); st = (s.op == OP_STORE);
        br = (s.op == OP_BRANCH); jal = (s.op == OP_JAL); jalr = (s.op == OP_JALR);
        ec = (s.op == OP_SYSTEM);
        known = r | im | ld | st | br | jal | jalr;
        e.mask = 1;
        e.fetch_cyc = int'(s.if_stall) + 1;
        if (ec || !known) begin
            e.cycles = 2; e.aow = 1; e.ecall = int'(ec);
            if (ec && s.ehalt) e.halts = 1;
            else begin e.pcw = 1; e.pwab = 3'b001; end
        end else if (br) begin
            e.aow = 1; e.mask |= 4; e.pcw = 1;
            if (s.bcond) begin e.cycles = 4; e.pwab = 3'b010; end
            else begin e.cycles = 3; e.pcsrc = 1; e.pwab = 3'b100; end
        end else begin
            e.cycles = ld ? 5 : 4; e.pcw = 1;
            e.pwab = jal ? 3'b010 : (jalr ? 3'b110 : 3'b001);
            e.regw = int'(!st); e.m2r = int'(ld);
            e.aow = (jal || jalr) ? 1 : 2;
            e.both = int'(r || im || ld);
            if (r) e.mask |= 2;
            if (im) e.mask |= 8;
            if (ld) begin e.drd = int'(s.mem_stall) + 1; e.cycles += int'(s.mem_stall); end
            if (st) begin e.dwr = int'(s.mem_stall) + 1; e.cycles += int'(s.mem_stall); end
        end
        e.cycles += int'(s.if_stall);
        return e;
    endfunction

    function automatic stim_t mk(input logic [6:0] op, input logic bc, input logic eh,
                                 input int unsigned fs, input int unsigned ms);
        stim_t s;
        s.op = op; s.bcond = bc; s.ehalt = eh; s.if_stall = fs; s.mem_stall = ms;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        logic [6:0] op;
        int unsigned k;
        k = $urandom_range(0, 19);
        if (k < 4) op = OP_R;
        else if (k < 7) op = OP_I;
        else if (k < 9) op = OP_LOAD;
        else if (k < 11) op = OP_STORE;
        else if (k < 14) op = OP_BRANCH;
        else if (k < 15) op = OP_JAL;
        else if (k < 16) op = OP_JALR;
        else if (k < 18) op = OP_SYSTEM;
        else begin
            case ($urandom_range(0, 3))
                0: op = 7'b0000000;
                1: op = 7'b1111111;
                2: op = 7'b0110111;
                default: op = 7'b0010111;
            endcase
        end
        return mk(op, 1'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    endfunction

    task automatic finalize(input int h);
        rec_t e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty got=1 exp=0");
            return;
        end
        e = exp_q.pop_front();
        acc.halts = h;
        cmp("cycles", acc.cycles, e.cycles);       cmp("fetch_cyc", acc.fetch_cyc, e.fetch_cyc);
        cmp("data_rd", acc.drd, e.drd);            cmp("data_wr", acc.dwr, e.dwr);
        cmp("pc_write_n", acc.pcw, e.pcw);         cmp("pc_source", acc.pcsrc, e.pcsrc);
        cmp("pc_alu_src", acc.pwab, e.pwab);       cmp("reg_write_n", acc.regw, e.regw);
        cmp("mem_to_reg", acc.m2r, e.m2r);         cmp("alu_out_write_n", acc.aow, e.aow);
        cmp("pc_rf_same_cyc", acc.both, e.both);   cmp("aluop_set", acc.mask, e.mask);
        cmp("is_ecall", acc.ecall, e.ecall);       cmp("halts", acc.halts, e.halts);
        sum_cyc += longint'(e.cycles);
        sum_ret += 1;
    endtask

    // Memory-side driver: issues an instruction at each new fetch and answers requests after planned stalls
    initial begin : driver
        bit          fetched;
        bit          data_started;
        bit          f, d;
        int unsigned wait_cnt;
        stim_t       cur;
        fetched = 1'b1; data_started = 1'b0; wait_cnt = 0; cur = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                fetched = 1'b1;
                mem_ready = 1'b0;
            end else begin
                f = mem_read && !i_or_d;
                d = i_or_d && (mem_read || mem_write);
                if (f && fetched && issue_en) begin
                    cur = (plan.size() != 0) ? plan.pop_front() : rand_stim();
                    opcode = cur.op; alu_bcond = cur.bcond; ecall_halt = cur.ehalt;
                    exp_q.push_back(model(cur));
                    issued++;
                    fetched = 1'b0; data_started = 1'b0; wait_cnt = cur.if_stall;
                end
                if ((f && !fetched) || d) begin
                    if (d && !data_started) begin
                        data_started = 1'b1;
                        wait_cnt = cur.mem_stall;
                    end
                    if (wait_cnt > 0) begin
                        mem_ready = 1'b0;
                        wait_cnt--;
                    end else begin
                        mem_ready = 1'b1;
                        if (f) fetched = 1'b1;
                    end
                end else if (f) begin
                    mem_ready = 1'b0;
                end else begin
                    mem_ready = 1'($urandom);
                    if (halted) begin
                        opcode = 7'($urandom); alu_bcond = 1'($urandom); ecall_halt = 1'($urandom);
                    end
                end
            end
        end
    end

    // Monitor: splits the output stream into instructions at each fresh fetch and scores them
    initial begin : monitor
        bit f;
        acc = '0; acc_on = 1'b0; prev_stall = 1'b0; sum_cyc = 0; sum_ret = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cmp("rst_ctl", {ctl, halted}, 0);
                cmp("rst_cycle_cnt", cycle_cnt, 0);
                cmp("rst_retire_cnt", retire_cnt, 0);
                exp_q.delete();
                acc_on = 1'b0; prev_stall = 1'b0; sum_cyc = 0; sum_ret = 0;
            end else if (halted) begin
                if (acc_on) finalize(1);
                acc_on = 1'b0;
                cmp("halt_ctl", ctl, 0);
                cmp("halt_cycle_cnt", cycle_cnt, exp_cnt(sum_cyc));
                cmp("halt_retire_cnt", retire_cnt, exp_cnt(sum_ret));
            end else begin
                f = mem_read && !i_or_d;
                if (f && !prev_stall) begin
                    if (acc_on) finalize(0);
                    cmp("start_cycle_cnt", cycle_cnt, exp_cnt(sum_cyc));
                    cmp("start_retire_cnt", retire_cnt, exp_cnt(sum_ret));
                    acc = '0;
                    acc_on = 1'b1;
                end
                if (acc_on) begin
                    acc.cycles++;
                    if (f) acc.fetch_cyc++;
                    if (i_or_d && mem_read) acc.drd++;
                    if (i_or_d && mem_write) acc.dwr++;
                    if (pc_write) begin
                        acc.pcw++; acc.pcsrc = int'(pc_source); acc.pwab = int'({alu_src_a, alu_src_b});
                    end
                    if (reg_write) begin acc.regw++; acc.m2r = int'(mem_to_reg); end
                    if (alu_out_write) acc.aow++;
                    if (pc_write && reg_write) acc.both++;
                    acc.mask |= (1 << ALUOp);
                    if (is_ecall) acc.ecall = 1;
                end
                prev_stall = f && !ir_write;
            end
        end
    end

    task automatic pulse_reset(input int n);
        reset_n = 1'b0;
        #1;
        cmp("rst_async_ctl", {ctl, halted}, 0);
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        cmp("post_rst_fetch", {mem_read, i_or_d}, 2'b10);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (halted) begin
            hcnt++;
            if (hcnt >= 4) begin
                hcnt = 0;
                pulse_reset(2);
            end
        end else begin
            hcnt = 0;
        end
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (issued < target && guard < 20000) begin
            step();
            guard++;
        end
        cmp("run_timeout", guard >= 20000, 0);
    endtask

    initial begin : main
        int  guard;
        bit  found;
        reset_n = 1'b0; opcode = '0; alu_bcond = 1'b0; ecall_halt = 1'b0; mem_ready = 1'b0;
        plan.push_back(mk(OP_R, 1'b0, 1'b0, 0, 0));
        plan.push_back(mk(OP_LOAD, 1'b0, 1'b0, 0, 2));
        plan.push_back(mk(OP_BRANCH, 1'b0, 1'b0, 0, 0));
        plan.push_back(mk(OP_BRANCH, 1'b1, 1'b0, 0, 0));
        plan.push_back(mk(OP_JAL, 1'b0, 1'b0, 0, 0));
        plan.push_back(mk(OP_JALR, 1'b1, 1'b0, 1, 0));
        plan.push_back(mk(OP_STORE, 1'b0, 1'b0, 2, 1));
        plan.push_back(mk(OP_I, 1'b0, 1'b0, 0, 0));
        plan.push_back(mk(7'b0110111, 1'b0, 1'b1, 0, 0));
        plan.push_back(mk(OP_SYSTEM, 1'b0, 1'b0, 0, 0));
        plan.push_back(mk(OP_SYSTEM, 1'b0, 1'b1, 1, 0));
        plan.push_back(mk(OP_SYSTEM, 1'b0, 1'b1, 0, 0));
        issue_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        cmp("first_fetch", {mem_read, i_or_d}, 2'b10);

        run_until(12);

        // Abandon an instruction in EX with an asynchronous reset
        found = 1'b0;
        guard = 0;
        while (!found && guard < 400) begin
            step();
            #2;
            if (reset_n && alu_src_a) found = 1'b1;
            guard++;
        end
        cmp("ex_found", found, 1);
        if (found) pulse_reset(2);

        run_until(issued + int'(N_RANDOM));

        issue_en = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            step();
            guard++;
        end
        cmp("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
